// File: rtl/lcd_bus_receiver.sv
// Receiver for the HD44780-style 8-bit LCD write bus: decodes commands and data writes
// and keeps a readable 2x16 character mirror plus the display/entry-mode state.
module lcd_bus_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CLR_CYCLES  = 32
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic [7:0] LCD_DATA,
  input  logic       LCD_RW,
  input  logic       LCD_EN,
  input  logic       LCD_RS,
  input  logic [4:0] iRD_ADDR,
  output logic [7:0] oRD_CHAR,
  output logic [6:0] oADDR,
  output logic       oDISP_ON,
  output logic       oCUR_ON,
  output logic       oINC,
  output logic       oBUSY,
  output logic       oWR_STB,
  output logic       oOVERRUN
);

  localparam int unsigned BUS_W = 11;
  localparam int unsigned CELLS = 32;
  localparam int unsigned CNT_W = $clog2(CLR_CYCLES + 1);
  localparam logic [7:0]  BLANK = 8'h20;
  // EN stages reset high so a pulse already in flight at reset cannot look like a fresh fall
  localparam logic [BUS_W-1:0] BUS_RST = 11'h001;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_CLEAR} state_t;

  state_t                              state_q, state_d;
  logic [SYNC_STAGES-1:0][BUS_W-1:0]   sync_q, sync_d;
  logic [1:0]                          en_hist_q, en_hist_d;
  logic                                armed_q, armed_d;
  logic [7:0]                          cmd_q, cmd_d;
  logic                                rs_q, rs_d;
  logic [6:0]                          addr_q, addr_d;
  logic                                disp_q, disp_d;
  logic                                cur_q, cur_d;
  logic                                inc_q, inc_d;
  logic                                busy_q, busy_d;
  logic                                wr_stb_q, wr_stb_d;
  logic                                overrun_q, overrun_d;
  logic [CNT_W-1:0]                    clr_cnt_q, clr_cnt_d;
  logic [7:0]                          rd_char_q, rd_char_d;
  logic [7:0]                          mirror_q [CELLS];

  logic [BUS_W-1:0] bus_last_c;
  logic             en_last_c, fall_c;
  logic             mem_we_c;
  logic [4:0]       mem_idx_c;
  logic [7:0]       mem_data_c;

  // DDRAM address step with the two-line wrap points
  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic up);
    logic [6:0] r;
    if (up) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  always_comb begin
    sync_d     = {sync_q[SYNC_STAGES-2:0], {LCD_DATA, LCD_RS, LCD_RW, LCD_EN}};
    bus_last_c = sync_q[SYNC_STAGES-1];
    en_last_c  = bus_last_c[0];
    en_hist_d  = {en_hist_q[0], en_last_c};
    armed_d    = armed_q | ~en_last_c;
    // Accept only falls after EN was seen high for two cycles and low at least once since reset
    fall_c     = armed_q & en_hist_q[1] & en_hist_q[0] & ~en_last_c;
    rd_char_d  = mirror_q[iRD_ADDR];

    state_d    = state_q;
    cmd_d      = cmd_q;
    rs_d       = rs_q;
    addr_d     = addr_q;
    disp_d     = disp_q;
    cur_d      = cur_q;
    inc_d      = inc_q;
    busy_d     = busy_q;
    wr_stb_d   = 1'b0;
    overrun_d  = overrun_q;
    clr_cnt_d  = clr_cnt_q;
    mem_we_c   = 1'b0;
    mem_idx_c  = 5'd0;
    mem_data_c = BLANK;

    if (fall_c && !bus_last_c[1]) begin
      if (busy_q) begin
        overrun_d = 1'b1;
      end else if (state_q == S_IDLE) begin
        cmd_d   = bus_last_c[10:3];
        rs_d    = bus_last_c[2];
        state_d = S_EXEC;
      end
    end

    case (state_q)
      S_EXEC: begin
        state_d = S_IDLE;
        if (rs_q) begin
          wr_stb_d = 1'b1;
          if (addr_q[6:4] == 3'b000) begin
            mem_we_c   = 1'b1;
            mem_idx_c  = {1'b0, addr_q[3:0]};
            mem_data_c = cmd_q;
          end else if (addr_q[6:4] == 3'b100) begin
            mem_we_c   = 1'b1;
            mem_idx_c  = {1'b1, addr_q[3:0]};
            mem_data_c = cmd_q;
          end
          addr_d = step_addr(addr_q, inc_q);
        end else begin
          casez (cmd_q)
            8'b1???????: addr_d = cmd_q[6:0];
            8'b0001????: if (!cmd_q[3]) addr_d = step_addr(addr_q, cmd_q[2]);
            8'b00001???: begin
              disp_d = cmd_q[2];
              cur_d  = cmd_q[1];
            end
            8'b000001??: inc_d = cmd_q[1];
            8'b0000001?: addr_d = 7'h00;
            8'b00000001: begin
              state_d   = S_CLEAR;
              busy_d    = 1'b1;
              clr_cnt_d = '0;
            end
            default: ;
          endcase
        end
      end
      S_CLEAR: begin
        if (clr_cnt_q < CNT_W'(CELLS)) begin
          mem_we_c   = 1'b1;
          mem_idx_c  = clr_cnt_q[4:0];
          mem_data_c = BLANK;
        end
        if (clr_cnt_q == CNT_W'(CELLS - 1)) begin
          addr_d = 7'h00;
          inc_d  = 1'b1;
        end
        if (clr_cnt_q == CNT_W'(CLR_CYCLES - 1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          clr_cnt_d = clr_cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= S_IDLE;
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= BUS_RST;
      en_hist_q <= 2'b11;
      armed_q   <= 1'b0;
      cmd_q     <= 8'h00;
      rs_q      <= 1'b0;
      addr_q    <= 7'h00;
      disp_q    <= 1'b0;
      cur_q     <= 1'b0;
      inc_q     <= 1'b1;
      busy_q    <= 1'b0;
      wr_stb_q  <= 1'b0;
      overrun_q <= 1'b0;
      clr_cnt_q <= '0;
      rd_char_q <= BLANK;
    end else begin
      state_q   <= state_d;
      sync_q    <= sync_d;
      en_hist_q <= en_hist_d;
      armed_q   <= armed_d;
      cmd_q     <= cmd_d;
      rs_q      <= rs_d;
      addr_q    <= addr_d;
      disp_q    <= disp_d;
      cur_q     <= cur_d;
      inc_q     <= inc_d;
      busy_q    <= busy_d;
      wr_stb_q  <= wr_stb_d;
      overrun_q <= overrun_d;
      clr_cnt_q <= clr_cnt_d;
      rd_char_q <= rd_char_d;
    end
  end

  // Character mirror; a same-cycle read sees the pre-write value
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      for (int i = 0; i < int'(CELLS); i++) mirror_q[i] <= BLANK;
    end else if (mem_we_c) begin
      mirror_q[mem_idx_c] <= mem_data_c;
    end
  end

  assign oRD_CHAR = rd_char_q;
  assign oADDR    = addr_q;
  assign oDISP_ON = disp_q;
  assign oCUR_ON  = cur_q;
  assign oINC     = inc_q;
  assign oBUSY    = busy_q;
  assign oWR_STB  = wr_stb_q;
  assign oOVERRUN = overrun_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives LCD bus transfers and checks mirror and state.
module tb_lcd_bus_receiver;
  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned CLR_CYCLES  = 32;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] lcd_data = 8'h00;
  logic       lcd_rw = 1'b0;
  logic       lcd_en = 1'b0;
  logic       lcd_rs = 1'b0;
  logic [4:0] rd_addr = 5'd0;
  logic [7:0] rd_char;
  logic [6:0] addr;
  logic       disp_on, cur_on, inc, busy, wr_stb, overrun;

  int checks = 0;
  int errors = 0;
  int stb_cnt = 0;
  int busy_cnt = 0;
  int base;
  logic [7:0] exp_mem [32];
  logic [7:0] got;

  lcd_bus_receiver #(.SYNC_STAGES(SYNC_STAGES), .CLR_CYCLES(CLR_CYCLES)) dut (
    .iCLK(clk), .iRST_N(rst_n), .LCD_DATA(lcd_data), .LCD_RW(lcd_rw), .LCD_EN(lcd_en),
    .LCD_RS(lcd_rs), .iRD_ADDR(rd_addr), .oRD_CHAR(rd_char), .oADDR(addr),
    .oDISP_ON(disp_on), .oCUR_ON(cur_on), .oINC(inc), .oBUSY(busy), .oWR_STB(wr_stb),
    .oOVERRUN(overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wr_stb) stb_cnt <= stb_cnt + 1;
    if (busy)   busy_cnt <= busy_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic lcd_xfer(input logic rs, input logic rw, input logic [7:0] d);
    @(negedge clk);
    lcd_data = d; lcd_rs = rs; lcd_rw = rw;
    @(negedge clk);
    lcd_en = 1'b1;
    repeat (3) @(negedge clk);
    lcd_en = 1'b0;
    repeat (SYNC_STAGES + 6) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] d);
    lcd_xfer(1'b0, 1'b0, d);
  endtask

  task automatic dat(input logic [7:0] d);
    lcd_xfer(1'b1, 1'b0, d);
  endtask

  task automatic read_char(input logic [4:0] idx, output logic [7:0] c);
    @(negedge clk);
    rd_addr = idx;
    @(posedge clk);
    #1 c = rd_char;
  endtask

  task automatic check_mirror();
    for (int i = 0; i < 32; i++) begin
      read_char(5'(i), got);
      check($sformatf("mirror[%0d]", i), 32'(got), 32'(exp_mem[i]));
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) @(negedge clk);
    check("busy_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
    repeat (3) @(negedge clk);
    check("rst_addr",    32'(addr),    32'h00);
    check("rst_inc",     32'(inc),     32'd1);
    check("rst_rdchar",  32'(rd_char), 32'h20);
    check("rst_disp",    32'(disp_on), 32'd0);
    check("rst_cur",     32'(cur_on),  32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_stb",     32'(wr_stb),  32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Init sequence and three characters on line 1
    base = stb_cnt;
    cmd(8'h38); cmd(8'h0C); cmd(8'h01); wait_idle(); cmd(8'h06); cmd(8'h80);
    dat(8'h42); dat(8'h65); dat(8'h6D);
    exp_mem[0] = 8'h42; exp_mem[1] = 8'h65; exp_mem[2] = 8'h6D;
    check_mirror();
    check("t1_addr", 32'(addr),    32'h03);
    check("t1_disp", 32'(disp_on), 32'd1);
    check("t1_cur",  32'(cur_on),  32'd0);
    check("t1_inc",  32'(inc),     32'd1);
    check("t1_stb",  32'(stb_cnt - base), 32'd3);

    // Line 2 write, then a write outside the visible window
    cmd(8'hC0); dat(8'h50);
    exp_mem[16] = 8'h50;
    read_char(5'd16, got);
    check("t2_m16",  32'(got),  32'h50);
    check("t2_addr", 32'(addr), 32'h41);
    cmd(8'hA7); dat(8'h58);
    check_mirror();
    check("t2_wrap", 32'(addr), 32'h40);

    // Decrement mode and the 0x00->0x67 cursor wrap
    cmd(8'h04); cmd(8'h8F); dat(8'h41); dat(8'h42);
    exp_mem[15] = 8'h41; exp_mem[14] = 8'h42;
    read_char(5'd15, got); check("t3_m15", 32'(got), 32'h41);
    read_char(5'd14, got); check("t3_m14", 32'(got), 32'h42);
    check("t3_addr", 32'(addr), 32'h0D);
    cmd(8'h80); cmd(8'h10);
    check("t3_left", 32'(addr), 32'h67);

    // Clear with a transfer arriving while busy
    base = busy_cnt;
    cmd(8'h01);
    cmd(8'h80);
    check("t4_busy_mid", 32'(busy), 32'd1);
    wait_idle();
    check("t4_overrun", 32'(overrun), 32'd1);
    check("t4_busy_len", 32'(busy_cnt - base), 32'(CLR_CYCLES));
    for (int i = 0; i < 32; i++) exp_mem[i] = 8'h20;
    check_mirror();
    check("t4_addr", 32'(addr), 32'h00);
    check("t4_inc",  32'(inc),  32'd1);

    // Read cycle and a too-short EN pulse are both ignored
    cmd(8'h85);
    base = stb_cnt;
    lcd_xfer(1'b1, 1'b1, 8'h41);
    check("t5_rw_addr", 32'(addr), 32'h05);
    read_char(5'd5, got); check("t5_rw_m5", 32'(got), 32'h20);
    check("t5_rw_stb", 32'(stb_cnt - base), 32'd0);
    @(negedge clk); lcd_data = 8'h41; lcd_rs = 1'b1; lcd_rw = 1'b0;
    @(negedge clk); lcd_en = 1'b1;
    @(negedge clk); lcd_en = 1'b0;
    repeat (10) @(negedge clk);
    check("t5_short_addr", 32'(addr), 32'h05);
    read_char(5'd5, got); check("t5_short_m5", 32'(got), 32'h20);
    check("t5_short_stb", 32'(stb_cnt - base), 32'd0);

    // Reset during CLEAR
    cmd(8'hCF); dat(8'h5A);
    read_char(5'd31, got); check("t6_m31_pre", 32'(got), 32'h5A);
    cmd(8'h01);
    repeat (5) @(negedge clk);
    check("t6_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("t6_busy",    32'(busy),    32'd0);
    check("t6_addr",    32'(addr),    32'h00);
    check("t6_disp",    32'(disp_on), 32'd0);
    check("t6_inc",     32'(inc),     32'd1);
    check("t6_overrun", 32'(overrun), 32'd0);
    check("t6_rdchar",  32'(rd_char), 32'h20);
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    read_char(5'd31, got); check("t6_m31_post", 32'(got), 32'h20);

    // Reset during EN high: the partial pulse must not execute
    base = stb_cnt;
    @(negedge clk); lcd_data = 8'h41; lcd_rs = 1'b1; lcd_rw = 1'b0;
    @(negedge clk); lcd_en = 1'b1;
    repeat (3) @(negedge clk); rst_n = 1'b0;
    repeat (2) @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk); lcd_en = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_en_stb",  32'(stb_cnt - base), 32'd0);
    check("t6_en_addr", 32'(addr), 32'h00);
    read_char(5'd0, got); check("t6_en_m0", 32'(got), 32'h20);
    dat(8'h4B);
    read_char(5'd0, got); check("t6_clean_m0", 32'(got), 32'h4B);
    check("t6_clean_addr", 32'(addr), 32'h01);
    check("t6_clean_stb",  32'(stb_cnt - base), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
